// File: rtl/video_timing_pkg.sv
// Timing presets for the HDMI output path and small elaboration helpers
// shared by the scan generator and its address sub-block.
package video_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit h_sync_active_low;
    bit v_sync_active_low;
    int pclk_khz;
  } timing_t;

  localparam timing_t TIMING_1080P60 = '{
    h_active: 1920, h_fp: 88, h_sync: 44, h_bp: 148,
    v_active: 1080, v_fp: 4,  v_sync: 5,  v_bp: 36,
    h_sync_active_low: 1'b0, v_sync_active_low: 1'b0, pclk_khz: 148500};

  localparam timing_t TIMING_720P60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    h_sync_active_low: 1'b0, v_sync_active_low: 1'b0, pclk_khz: 74250};

  localparam timing_t TIMING_800X600P60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_sync_active_low: 1'b0, v_sync_active_low: 1'b0, pclk_khz: 40000};

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fbuf_addr_gen.sv
// Incremental row-major framebuffer address: (y>>s)*(H_ACTIVE>>s) + (x>>s)
// built from a column counter and a row base, no multiplier. One register stage.
module fbuf_addr_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = TIMING_1080P60.h_active,
  parameter int COORD_W  = 13,
  parameter int ADDR_W   = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         scale,
  input  logic               active,
  input  logic               frame_end,
  output logic [ADDR_W-1:0]  addr
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0]  H_ACT_A = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0]  ONE_A   = ADDR_W'(1);

  logic [ADDR_W-1:0]  col_addr, row_base, stride;
  logic [COORD_W-1:0] mask;
  logic               line_end;

  assign mask     = ~({COORD_W{1'b1}} << scale);
  assign stride   = H_ACT_A >> scale;
  assign line_end = active && (x == X_LAST);

  // col_addr/row_base always describe the current (x,y), so they clear on the
  // wrap cycle and are ready at the first pixel of the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_addr <= '0;
      row_base <= '0;
      addr     <= '0;
    end else begin
      addr <= active ? (row_base + col_addr) : '0;
      if (frame_end) begin
        col_addr <= '0;
        row_base <= '0;
      end else if (active) begin
        if (line_end) begin
          col_addr <= '0;
          if ((y & mask) == mask) row_base <= row_base + stride;
        end else if ((x & mask) == mask) begin
          col_addr <= col_addr + ONE_A;
        end
      end
    end
  end

endmodule

// File: rtl/video_scan_gen.sv
// Parametrised scan/timing generator: h/v counters, sync/vde/sof/eof decode,
// per-frame upscale latch and a control delay line aligned to the address path.
module video_scan_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE          = TIMING_1080P60.h_active,
  parameter int H_FP              = TIMING_1080P60.h_fp,
  parameter int H_SYNC            = TIMING_1080P60.h_sync,
  parameter int H_BP              = TIMING_1080P60.h_bp,
  parameter int V_ACTIVE          = TIMING_1080P60.v_active,
  parameter int V_FP              = TIMING_1080P60.v_fp,
  parameter int V_SYNC            = TIMING_1080P60.v_sync,
  parameter int V_BP              = TIMING_1080P60.v_bp,
  parameter bit H_SYNC_ACTIVE_LOW = 1'b0,
  parameter bit V_SYNC_ACTIVE_LOW = 1'b0,
  parameter int MAX_SCALE_LOG2    = 3,
  parameter int COORD_W           = 13,
  parameter int ADDR_W            = 17,
  parameter int CONTROL_DELAY     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         scale_log2,
  output logic [1:0]         scale_active,
  output logic               hsync,
  output logic               vsync,
  output logic               vde,
  output logic               sof,
  output logic               eof,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [ADDR_W-1:0]  fbuf_addr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);
  localparam logic [1:0]         S_MAX  = 2'(MAX_SCALE_LOG2);

  typedef struct packed {
    logic [1:0]         scale;
    logic               hsync;
    logic               vsync;
    logic               vde;
    logic               sof;
    logic               eof;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{scale: 2'd0, hsync: H_SYNC_ACTIVE_LOW,
                                 vsync: V_SYNC_ACTIVE_LOW, vde: 1'b0, sof: 1'b0,
                                 eof: 1'b0, x: '0, y: '0};

  logic [COORD_W-1:0] h, v;
  logic [1:0]         scale_q;
  logic               frame_end;
  ctrl_t              raw;
  ctrl_t              ctrl_pipe [CONTROL_DELAY];
  logic [ADDR_W-1:0]  addr_s1;

  assign frame_end = (h == H_LAST) && (v == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h       <= '0;
      v       <= '0;
      scale_q <= '0;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + ONE_C;
      end else begin
        h <= h + ONE_C;
      end
      if (frame_end) scale_q <= (scale_log2 > S_MAX) ? S_MAX : scale_log2;
    end
  end

  always_comb begin
    raw       = CTRL_RST;
    raw.scale = scale_q;
    raw.vde   = (h < H_ACT) && (v < V_ACT);
    raw.hsync = ((h >= HS_BEG) && (h < HS_END)) ^ H_SYNC_ACTIVE_LOW;
    raw.vsync = ((v >= VS_BEG) && (v < VS_END)) ^ V_SYNC_ACTIVE_LOW;
    raw.eof   = (v >= V_ACT);
    raw.sof   = (h == '0) && (v == '0);
    raw.x     = raw.vde ? h : '0;
    raw.y     = raw.vde ? v : '0;
  end

  fbuf_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .COORD_W  (COORD_W),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (h),
    .y         (v),
    .scale     (scale_q),
    .active    (raw.vde),
    .frame_end (frame_end),
    .addr      (addr_s1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CONTROL_DELAY; i++) ctrl_pipe[i] <= CTRL_RST;
    end else begin
      ctrl_pipe[0] <= raw;
      for (int i = 1; i < CONTROL_DELAY; i++) ctrl_pipe[i] <= ctrl_pipe[i-1];
    end
  end

  // The address block already supplies the first stage; only extra delay is added here.
  generate
    if (CONTROL_DELAY == 1) begin : g_addr_direct
      assign fbuf_addr = addr_s1;
    end else begin : g_addr_dly
      logic [ADDR_W-1:0] addr_pipe [CONTROL_DELAY-1];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < CONTROL_DELAY-1; i++) addr_pipe[i] <= '0;
        end else begin
          addr_pipe[0] <= addr_s1;
          for (int i = 1; i < CONTROL_DELAY-1; i++) addr_pipe[i] <= addr_pipe[i-1];
        end
      end
      assign fbuf_addr = addr_pipe[CONTROL_DELAY-2];
    end
  endgenerate

  assign scale_active = ctrl_pipe[CONTROL_DELAY-1].scale;
  assign hsync        = ctrl_pipe[CONTROL_DELAY-1].hsync;
  assign vsync        = ctrl_pipe[CONTROL_DELAY-1].vsync;
  assign vde          = ctrl_pipe[CONTROL_DELAY-1].vde;
  assign sof          = ctrl_pipe[CONTROL_DELAY-1].sof;
  assign eof          = ctrl_pipe[CONTROL_DELAY-1].eof;
  assign pixel_x      = ctrl_pipe[CONTROL_DELAY-1].x;
  assign pixel_y      = ctrl_pipe[CONTROL_DELAY-1].y;

endmodule

// File: tb/tb_video_scan_gen.sv
// Directed bench for video_scan_gen on a tiny 24x12 timing (16x8 active).
module tb_video_scan_gen;

  localparam int COORD_W = 13;
  localparam int ADDR_W  = 17;
  localparam int FRAME   = 288;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         scale_log2;
  logic [1:0]         scale_active;
  logic               hsync, vsync, vde, sof, eof;
  logic [COORD_W-1:0] pixel_x, pixel_y;
  logic [ADDR_W-1:0]  fbuf_addr;

  int n_chk  = 0;
  int n_fail = 0;
  int idx    = 0;

  video_scan_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_ACTIVE_LOW(1'b0), .V_SYNC_ACTIVE_LOW(1'b0),
    .MAX_SCALE_LOG2(2), .COORD_W(COORD_W), .ADDR_W(ADDR_W), .CONTROL_DELAY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scale_log2(scale_log2), .scale_active(scale_active),
    .hsync(hsync), .vsync(vsync), .vde(vde), .sof(sof), .eof(eof),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .fbuf_addr(fbuf_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, v;
    int hs, vs, de, sf, ef, x, y, addr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (idx %0d)", name, act, exp, idx);
    end
  endtask

  // Outputs seen at a negedge describe counter index idx (ticks since release - 1).
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idx++;
  endtask

  task automatic goto_pos(input int f, input int h, input int v);
    int target;
    int n;
    target = f*FRAME + v*24 + h;
    n = 0;
    while (idx < target && n < 2*FRAME) begin
      tick();
      n++;
    end
    chk($sformatf("position f%0d h%0d v%0d", f, h, v), idx, target);
  endtask

  initial begin
    tbl[0]  = '{h:0,  v:0,  hs:0, vs:0, de:1, sf:1, ef:0, x:0,  y:0, addr:0};
    tbl[1]  = '{h:15, v:0,  hs:0, vs:0, de:1, sf:0, ef:0, x:15, y:0, addr:15};
    tbl[2]  = '{h:16, v:0,  hs:0, vs:0, de:0, sf:0, ef:0, x:0,  y:0, addr:0};
    tbl[3]  = '{h:17, v:0,  hs:0, vs:0, de:0, sf:0, ef:0, x:0,  y:0, addr:0};
    tbl[4]  = '{h:18, v:0,  hs:1, vs:0, de:0, sf:0, ef:0, x:0,  y:0, addr:0};
    tbl[5]  = '{h:20, v:0,  hs:1, vs:0, de:0, sf:0, ef:0, x:0,  y:0, addr:0};
    tbl[6]  = '{h:21, v:0,  hs:0, vs:0, de:0, sf:0, ef:0, x:0,  y:0, addr:0};
    tbl[7]  = '{h:0,  v:1,  hs:0, vs:0, de:1, sf:0, ef:0, x:0,  y:1, addr:16};
    tbl[8]  = '{h:15, v:7,  hs:0, vs:0, de:1, sf:0, ef:0, x:15, y:7, addr:127};
    tbl[9]  = '{h:5,  v:8,  hs:0, vs:0, de:0, sf:0, ef:1, x:0,  y:0, addr:0};
    tbl[10] = '{h:0,  v:9,  hs:0, vs:1, de:0, sf:0, ef:1, x:0,  y:0, addr:0};
    tbl[11] = '{h:19, v:10, hs:1, vs:1, de:0, sf:0, ef:1, x:0,  y:0, addr:0};
    tbl[12] = '{h:0,  v:11, hs:0, vs:0, de:0, sf:0, ef:1, x:0,  y:0, addr:0};
    tbl[13] = '{h:23, v:11, hs:0, vs:0, de:0, sf:0, ef:1, x:0,  y:0, addr:0};

    rst_n = 1'b0;
    scale_log2 = 2'd0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("reset hsync", int'(hsync), 0);
    chk("reset vsync", int'(vsync), 0);
    chk("reset vde",   int'(vde), 0);
    chk("reset sof",   int'(sof), 0);
    chk("reset eof",   int'(eof), 0);
    chk("reset addr",  int'(fbuf_addr), 0);
    chk("reset scale", int'(scale_active), 0);

    rst_n = 1'b1;
    idx = -1;
    tick();

    // Frame 0, 1x: timing decode and linear addressing
    for (int i = 0; i < 14; i++) begin
      goto_pos(0, tbl[i].h, tbl[i].v);
      chk($sformatf("v%0d hsync",  i), int'(hsync), tbl[i].hs);
      chk($sformatf("v%0d vsync",  i), int'(vsync), tbl[i].vs);
      chk($sformatf("v%0d vde",    i), int'(vde), tbl[i].de);
      chk($sformatf("v%0d sof",    i), int'(sof), tbl[i].sf);
      chk($sformatf("v%0d eof",    i), int'(eof), tbl[i].ef);
      chk($sformatf("v%0d x",      i), int'(pixel_x), tbl[i].x);
      chk($sformatf("v%0d y",      i), int'(pixel_y), tbl[i].y);
      chk($sformatf("v%0d addr",   i), int'(fbuf_addr), tbl[i].addr);
      chk($sformatf("v%0d scale",  i), int'(scale_active), 0);
    end

    // Frame 1: mid-frame request for 4x must not affect this frame
    goto_pos(1, 3, 2);
    scale_log2 = 2'd2;
    goto_pos(1, 15, 7);
    chk("midframe addr",  int'(fbuf_addr), 127);
    chk("midframe scale", int'(scale_active), 0);

    // Frame 2: 4x in effect
    goto_pos(2, 0, 0);
    chk("f2 sof",   int'(sof), 1);
    chk("f2 scale", int'(scale_active), 2);
    chk("f2 addr0", int'(fbuf_addr), 0);
    for (int yy = 4; yy < 8; yy++)
      for (int xx = 4; xx < 8; xx++) begin
        goto_pos(2, xx, yy);
        chk($sformatf("4x block (%0d,%0d)", xx, yy), int'(fbuf_addr), 5);
      end
    goto_pos(2, 15, 7);
    chk("4x addr (15,7)", int'(fbuf_addr), 7);
    goto_pos(2, 20, 10);
    scale_log2 = 2'd3;

    // Frame 3: clamped exponent, then whole-frame statistics
    goto_pos(3, 0, 0);
    chk("clamp scale", int'(scale_active), 2);
    begin
      int c_de, c_hs, c_vs, c_ef, c_sf;
      c_de = 0; c_hs = 0; c_vs = 0; c_ef = 0; c_sf = 0;
      for (int k = 0; k < FRAME; k++) begin
        tick();
        c_de += int'(vde);
        c_hs += int'(hsync);
        c_vs += int'(vsync);
        c_ef += int'(eof);
        c_sf += int'(sof);
      end
      chk("frame sof count", c_sf, 1);
      chk("period end sof",  int'(sof), 1);
      chk("vde per frame",   c_de, 128);
      chk("hsync per frame", c_hs, 36);
      chk("vsync per frame", c_vs, 48);
      chk("eof per frame",   c_ef, 96);
    end

    // Frame 4: reset pulse while counters sit at (10,4)
    goto_pos(4, 9, 4);
    chk("pre-reset vde", int'(vde), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst vde",   int'(vde), 0);
    chk("midrst sof",   int'(sof), 0);
    chk("midrst addr",  int'(fbuf_addr), 0);
    chk("midrst x",     int'(pixel_x), 0);
    chk("midrst scale", int'(scale_active), 0);
    rst_n = 1'b1;
    idx = -1;
    tick();
    chk("restart sof",  int'(sof), 1);
    chk("restart vde",  int'(vde), 1);
    chk("restart x",    int'(pixel_x), 0);
    chk("restart y",    int'(pixel_y), 0);
    chk("restart addr", int'(fbuf_addr), 0);
    tick();
    chk("restart sof low", int'(sof), 0);
    chk("restart addr1",   int'(fbuf_addr), 1);
    chk("restart x1",      int'(pixel_x), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
